// File: rtl/mem_line_responder.sv
// Memory-side line responder: fixed-latency 128-bit line read/write with a one-cycle ready pulse.
// Define MEM_RESP_PROTO_CHECK_EN to build the sticky protocol checker behind proto_err.
module mem_line_responder #(
   parameter int LATENCY    = 8,
   parameter int DEPTH_LOG2 = 10
) (
   input  logic         clk,
   input  logic         proc_reset_n,
   input  logic         mem_read,
   input  logic         mem_write,
   input  logic [27:0]  mem_addr,
   input  logic [127:0] mem_wdata,
   output logic [127:0] mem_rdata,
   output logic         mem_ready,
   output logic         proto_err
);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t                  state;
   logic [7:0]              cnt;
   logic                    is_wr;
   logic                    req;
   logic                    access;
   logic [DEPTH_LOG2-1:0]   idx;
   logic [127:0]            lines [0:(1<<DEPTH_LOG2)-1];
   logic                    unused_addr_hi;

   assign req            = mem_read | mem_write;
   assign idx            = mem_addr[DEPTH_LOG2-1:0];
   assign unused_addr_hi = ^mem_addr[27:DEPTH_LOG2];
   // Address/data are sampled on the access cycle, not at detection: the cache registers them late.
   assign access         = (state == BUSY) && req && (cnt == 8'd1);

   // Array has no reset; a reset mid-access forces state to IDLE so the write never fires.
   always_ff @(posedge clk) begin
      if (access && is_wr)
         lines[idx] <= mem_wdata;
   end

   always_ff @(posedge clk or negedge proc_reset_n) begin
      if (!proc_reset_n) begin
         state     <= IDLE;
         cnt       <= 8'd0;
         is_wr     <= 1'b0;
         mem_ready <= 1'b0;
         mem_rdata <= '0;
      end else begin
         mem_ready <= 1'b0;
         case (state)
            IDLE: begin
               if (req) begin
                  cnt   <= 8'(LATENCY - 1);
                  is_wr <= mem_write;
                  state <= BUSY;
               end
            end
            BUSY: begin
               cnt <= cnt - 8'd1;
               if (!req) begin
                  state <= IDLE;
               end else if (cnt == 8'd1) begin
                  mem_ready <= 1'b1;
                  if (!is_wr)
                     mem_rdata <= lines[idx];
                  state <= DONE;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

`ifdef MEM_RESP_PROTO_CHECK_EN
   logic [27:0] addr_first;
   logic        first_busy;

   assign first_busy = (state == BUSY) && (cnt == 8'(LATENCY - 1));

   always_ff @(posedge clk or negedge proc_reset_n) begin
      if (!proc_reset_n) begin
         proto_err  <= 1'b0;
         addr_first <= '0;
      end else begin
         if (first_busy)
            addr_first <= mem_addr;
         if (mem_read && mem_write)
            proto_err <= 1'b1;
         if (state == BUSY) begin
            if (!req)
               proto_err <= 1'b1;
            else begin
               if (!first_busy && (mem_addr != addr_first))
                  proto_err <= 1'b1;
               if (mem_write != is_wr)
                  proto_err <= 1'b1;
            end
         end
      end
   end
`else
   assign proto_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_line_responder.sv
// Directed + randomized bench for mem_line_responder against a line-array model.
module tb_mem_line_responder;
   localparam int LAT = 4;
   localparam int DL  = 10;
`ifdef MEM_RESP_PROTO_CHECK_EN
   localparam logic PEXP = 1'b1;
`else
   localparam logic PEXP = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         proc_reset_n = 1'b0;
   logic         mem_read = 1'b0;
   logic         mem_write = 1'b0;
   logic [27:0]  mem_addr = '0;
   logic [127:0] mem_wdata = '0;
   logic [127:0] mem_rdata;
   logic         mem_ready;
   logic         proto_err;

   mem_line_responder #(.LATENCY(LAT), .DEPTH_LOG2(DL)) dut (
      .clk(clk), .proc_reset_n(proc_reset_n), .mem_read(mem_read), .mem_write(mem_write),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .mem_ready(mem_ready), .proto_err(proto_err));

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int           n_asrt = 0;
   int           n_fail = 0;
   logic [127:0] model [int];
   logic [127:0] exp_rdata = '0;
   int           last_rdy = 0;
   int           prev_rdy = 0;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_asrt++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Cache-like access: strobe first, real address one cycle later, drop one cycle after ready.
   task automatic access(input bit wr, input bit both, input logic [27:0] addr,
                         input logic [127:0] data, input string tag);
      int idx, nrdy, rcyc;
      idx = int'(addr[DL-1:0]);
      mem_write = wr;
      mem_read  = !wr || both;
      mem_addr  = ~addr;
      mem_wdata = ~data;
      nrdy = 0;
      rcyc = 0;
      if (wr) model[idx] = data;
      else    exp_rdata  = model[idx];
      for (int c = 1; c <= LAT + 2; c++) begin
         @(posedge clk); #1;
         if (c == 1) begin
            mem_addr  = addr;
            mem_wdata = data;
         end
         if (mem_ready) begin
            nrdy++;
            rcyc     = c;
            prev_rdy = last_rdy;
            last_rdy = cyc;
         end
         if (c == LAT + 1) begin
            mem_read  = 1'b0;
            mem_write = 1'b0;
            chk({tag, " rdata@rdy+1"}, mem_rdata, exp_rdata);
         end
         if (c == LAT + 2)
            chk({tag, " rdata@rdy+2"}, mem_rdata, exp_rdata);
      end
      chk({tag, " latency"}, 128'(rcyc), 128'(LAT));
      chk({tag, " pulses"}, 128'(nrdy), 128'd1);
   endtask

   initial begin
      int nrdy;
      logic [127:0] d;
      logic [27:0]  a;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("reset ready", 128'(mem_ready), 128'd0);
      chk("reset rdata", mem_rdata, 128'd0);
      chk("reset proto", 128'(proto_err), 128'd0);
      proc_reset_n = 1'b1;
      @(posedge clk); #1;

      access(1'b1, 1'b0, 28'h0000005, 128'hDEAD_0000_0000_0000_0000_0000_0000_0001, "wr5");
      chk("write leaves rdata", mem_rdata, 128'd0);
      access(1'b0, 1'b0, 28'h0000005, 128'd0, "rd5");

      // Aliasing modulo 2^DL
      access(1'b1, 1'b0, 28'h0000405, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, "wr405");
      access(1'b0, 1'b0, 28'h0000005, 128'd0, "rd5alias");

      // Write-back then allocate on the same line
      access(1'b1, 1'b0, 28'h0000003, 128'hCAFE_F00D_0000_1111_2222_3333_4444_5555, "wr3");
      access(1'b0, 1'b0, 28'h0000003, 128'd0, "rd3");
      chk("b2b spacing", 128'(last_rdy - prev_rdy), 128'(LAT + 2));
      chk("proto clean", 128'(proto_err), 128'd0);

      // Aborted write: strobe dropped two cycles in
      mem_write = 1'b1; mem_read = 1'b0; mem_addr = 28'h0000003; mem_wdata = '1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      mem_write = 1'b0;
      nrdy = 0;
      for (int c = 0; c < LAT + 3; c++) begin
         @(posedge clk); #1;
         if (mem_ready) nrdy++;
      end
      chk("abort pulses", 128'(nrdy), 128'd0);
      chk("abort proto", 128'(proto_err), 128'(PEXP));
      access(1'b0, 1'b0, 28'h0000003, 128'd0, "rd3 after abort");

      // Reset in the middle of a write
      mem_write = 1'b1; mem_read = 1'b0; mem_addr = 28'h0000005; mem_wdata = '0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      proc_reset_n = 1'b0;
      mem_write    = 1'b0;
      #1;
      chk("rst ready", 128'(mem_ready), 128'd0);
      chk("rst rdata", mem_rdata, 128'd0);
      chk("rst proto", 128'(proto_err), 128'd0);
      exp_rdata = '0;
      @(posedge clk); #1;
      proc_reset_n = 1'b1;
      nrdy = 0;
      for (int c = 0; c < LAT + 2; c++) begin
         @(posedge clk); #1;
         if (mem_ready) nrdy++;
      end
      chk("rst pulses", 128'(nrdy), 128'd0);
      access(1'b0, 1'b0, 28'h0000005, 128'd0, "rd5 after rst");

      // Read and write together behave as a write
      access(1'b1, 1'b1, 28'h0000007, 128'h7777_0000_AAAA_5555_0000_1234_5678_9ABC, "both");
      chk("both proto", 128'(proto_err), 128'(PEXP));
      access(1'b0, 1'b0, 28'h0000007, 128'd0, "rd7");

      // Randomized traffic over a small aliased pool
      for (int i = 0; i < 24; i++) begin
         a = {$urandom_range(0, 255), 10'd0} | 28'($urandom_range(0, 7) * 37);
         d = {$urandom, $urandom, $urandom, $urandom};
         if (!model.exists(int'(a[DL-1:0])) || ($urandom_range(0, 1) == 1))
            access(1'b1, 1'b0, a, d, "rand wr");
         else
            access(1'b0, 1'b0, a, 128'd0, "rand rd");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
      $finish;
   end
endmodule
